pmod_enc_conditioner: RTL and testbench

PMOD_ENC_CONDITIONER -- requirements
Module: pmod_enc_conditioner

---
 rtl/pmod_enc_conditioner_pkg.sv | 20 ++
 rtl/pmod_enc_conditioner_debounce_ch.sv | 96 +++++++++
 rtl/pmod_enc_conditioner.sv | 87 ++++++++
 tb/tb_pmod_enc_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_enc_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// pmod_enc_pkg
// Shared types and constants for the Pmod rotary-encoder input conditioner.
//   db_state_t       : per-channel debounce FSM state (STABLE, PENDING)
//   DB_CYCLES_DEF    : default stable-cycle count before a clean level changes
//   SYNC_STAGES_DEF  : default synchronizer depth per raw input
//   GLITCH_CNT_W     : width of the saturating rejected-transition counter
// -----------------------------------------------------------------------------
package pmod_enc_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  localparam int DB_CYCLES_DEF   = 100000;  // 1 ms at 100 MHz
  localparam int SYNC_STAGES_DEF = 2;
  localparam int GLITCH_CNT_W    = 16;

endpackage : pmod_enc_pkg

// File: rtl/pmod_enc_conditioner_debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One conditioned input channel: synchronizer chain, STABLE/PENDING debounce
// FSM with a hold counter, and the registered clean level.
//   Parameters : DB_CYCLES   - cycles sync must differ from clean (in PENDING)
//                SYNC_STAGES - synchronizer depth
//                INIT        - idle/reset level of this pin
//   Ports      : clk, rst_n  - clock, async active-low reset
//                raw         - asynchronous pin
//                clean       - debounced level (registered)
//                commit      - 1 in the cycle whose edge updates clean
//                glitch      - 1 in the cycle whose edge rejects a pending change
// -----------------------------------------------------------------------------
module debounce_ch
  import pmod_enc_pkg::*;
#(
  parameter int   DB_CYCLES   = DB_CYCLES_DEF,
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic commit,
  output logic glitch
);

  localparam int                CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;

  // NOTE: the synchronizer resets to the pin's idle level so that the FSM sees
  // no phantom transition in the first cycles after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    clean_d = clean_q;
    commit  = 1'b0;
    glitch  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (sync != clean_q) state_d = PENDING;
      end
      PENDING: begin
        if (sync == clean_q) begin
          // Input bounced back before the hold time elapsed.
          state_d = STABLE;
          glitch  = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE;
          clean_d = sync;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign clean = clean_q;

endmodule : debounce_ch

// File: rtl/pmod_enc_conditioner.sv
// -----------------------------------------------------------------------------
// pmod_enc_conditioner
// Synchronizes and debounces the Pmod encoder A/B quadrature pins and push
// button, generates a one-cycle press pulse and counts rejected glitches.
//   Parameters : DB_CYCLES (2..2^20), SYNC_STAGES (2..4)
//   Inputs     : clk, rst_n (async active-low, released synchronously upstream)
//                a_raw, b_raw (idle high), btn_raw (active high)
//   Outputs    : a_clean, b_clean, btn_clean - debounced levels
//                btn_press  - one cycle high in the first cycle btn_clean is 1
//                glitch_cnt - saturating count of rejected transitions
//   Build option: define PMOD_ENC_GLITCH_CNT_EN to include the glitch counter;
//                 otherwise glitch_cnt is tied to zero.
// -----------------------------------------------------------------------------
module pmod_enc_conditioner
  import pmod_enc_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_raw,
  input  logic                    b_raw,
  input  logic                    btn_raw,
  output logic                    a_clean,
  output logic                    b_clean,
  output logic                    btn_clean,
  output logic                    btn_press,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  logic a_commit,   b_commit,   btn_commit;
  logic a_glitch,   b_glitch,   btn_glitch;

  debounce_ch #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_ch_a (
    .clk(clk), .rst_n(rst_n), .raw(a_raw),
    .clean(a_clean), .commit(a_commit), .glitch(a_glitch)
  );

  debounce_ch #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .raw(b_raw),
    .clean(b_clean), .commit(b_commit), .glitch(b_glitch)
  );

  debounce_ch #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_ch_btn (
    .clk(clk), .rst_n(rst_n), .raw(btn_raw),
    .clean(btn_clean), .commit(btn_commit), .glitch(btn_glitch)
  );

  // A commit while the clean level is still 0 is the 0->1 edge; the pulse is
  // registered on the same edge that raises btn_clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_press <= 1'b0;
    end else begin
      btn_press <= btn_commit & ~btn_clean;
    end
  end

`ifdef PMOD_ENC_GLITCH_CNT_EN
  logic [1:0]              glitch_sum;
  logic [GLITCH_CNT_W:0]   cnt_sum;

  // Up to three channels can reject a transition on the same edge.
  assign glitch_sum = 2'(a_glitch) + 2'(b_glitch) + 2'(btn_glitch);
  assign cnt_sum    = {1'b0, glitch_cnt} + (GLITCH_CNT_W + 1)'(glitch_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (cnt_sum[GLITCH_CNT_W]) begin
      glitch_cnt <= '1;
    end else begin
      glitch_cnt <= cnt_sum[GLITCH_CNT_W-1:0];
    end
  end

  logic unused_commit;
  assign unused_commit = a_commit ^ b_commit;
`else
  assign glitch_cnt = '0;

  logic unused_strobes;
  assign unused_strobes = ^{a_commit, b_commit, a_glitch, b_glitch, btn_glitch};
`endif

endmodule : pmod_enc_conditioner

// File: tb/tb_pmod_enc_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pmod_enc_conditioner
// Self-checking bench for pmod_enc_conditioner with DB_CYCLES=4, SYNC_STAGES=2.
// The reference model tracks, per channel, how long the synchronized input has
// differed from the clean level: a run of DB_CYCLES+1 samples is accepted, a
// shorter run that returns to the clean level is a glitch. Cycle 0 of an edge
// is the clock edge that first samples the new raw level.
// -----------------------------------------------------------------------------
module tb_pmod_enc_conditioner;

  localparam int DB = 4;
  localparam int SS = 2;
`ifdef PMOD_ENC_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_raw = 1'b1;
  logic        b_raw = 1'b1;
  logic        btn_raw = 1'b0;
  logic        a_clean, b_clean, btn_clean, btn_press;
  logic [15:0] glitch_cnt;

  int total = 0;
  int bad   = 0;

  pmod_enc_conditioner #(.DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .a_raw(a_raw), .b_raw(b_raw), .btn_raw(btn_raw),
    .a_clean(a_clean), .b_clean(b_clean), .btn_clean(btn_clean),
    .btn_press(btn_press), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (channel 0=a, 1=b, 2=btn) ----------------
  bit m_dly[3][SS];   // raw samples in flight to the debouncer
  bit m_clean[3];
  int m_run[3];       // consecutive samples differing from clean
  int m_gcnt;
  bit m_press;

  function automatic bit idle_level(int ch);
    return (ch != 2);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      for (int i = 0; i < SS; i++) m_dly[ch][i] = idle_level(ch);
      m_clean[ch] = idle_level(ch);
      m_run[ch]   = 0;
    end
    m_gcnt  = 0;
    m_press = 1'b0;
  endtask

  task automatic model_edge();
    bit r[3];
    bit s;
    int n;
    r[0] = a_raw; r[1] = b_raw; r[2] = btn_raw;
    n = 0;
    m_press = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      s = m_dly[ch][SS-1];
      for (int i = SS - 1; i > 0; i--) m_dly[ch][i] = m_dly[ch][i-1];
      m_dly[ch][0] = r[ch];
      if (s != m_clean[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DB + 1) begin
          m_clean[ch] = s;
          m_run[ch]   = 0;
          if (ch == 2 && s) m_press = 1'b1;
        end
      end else if (m_run[ch] > 0) begin
        n++;
        m_run[ch] = 0;
      end
    end
    m_gcnt = (m_gcnt + n > 65535) ? 65535 : m_gcnt + n;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_gcnt(int v);
    return GC_EN ? 16'(v) : 16'h0000;
  endfunction

  task automatic check_all();
    check("a_clean",    {15'b0, a_clean},   {15'b0, m_clean[0]});
    check("b_clean",    {15'b0, b_clean},   {15'b0, m_clean[1]});
    check("btn_clean",  {15'b0, btn_clean}, {15'b0, m_clean[2]});
    check("btn_press",  {15'b0, btn_press}, {15'b0, m_press});
    check("glitch_cnt", glitch_cnt,         exp_gcnt(m_gcnt));
  endtask

  // One clock: model follows the edge, outputs are sampled 1 ns later, and
  // stimulus changes after that, well away from the next edge.
  task automatic tick(input bit chk = 1'b1);
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    if (chk) check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int g0;
    int rem[3];
    bit r[3];

    // Reset state, held with no stimulus.
    model_reset();
    rst_n = 1'b0;
    #1;
    check_all();
    ticks(3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ticks(20);
    check("idle_a",    {15'b0, a_clean},   16'd1);
    check("idle_btn",  {15'b0, btn_clean}, 16'd0);

    // a_raw falls and is held: a_clean falls 6 cycles after the sampling edge.
    a_raw = 1'b0;
    ticks(6);
    check("a_lat_before", {15'b0, a_clean}, 16'd1);
    tick();
    check("a_lat_at",     {15'b0, a_clean}, 16'd0);
    check("a_lat_b",      {15'b0, b_clean}, 16'd1);
    ticks(13);
    check("a_lat_gcnt",   glitch_cnt, 16'd0);
    a_raw = 1'b1;
    ticks(20);

    // Two-cycle low pulse on b is rejected.
    b_raw = 1'b0;
    ticks(2);
    b_raw = 1'b1;
    ticks(10);
    check("b_pulse_clean", {15'b0, b_clean}, 16'd1);
    check("b_pulse_gcnt",  glitch_cnt, exp_gcnt(1));

    // Button press: clean rises after 6 cycles, one press pulse, none on release.
    btn_raw = 1'b1;
    ticks(6);
    check("btn_before",  {15'b0, btn_clean}, 16'd0);
    tick();
    check("btn_rise",    {15'b0, btn_clean}, 16'd1);
    check("btn_press1",  {15'b0, btn_press}, 16'd1);
    tick();
    check("btn_press0",  {15'b0, btn_press}, 16'd0);
    ticks(15);
    btn_raw = 1'b0;
    ticks(20);
    check("btn_release", {15'b0, btn_clean}, 16'd0);

    // Simultaneous one-cycle glitches on a and b: +2 in a single step.
    g0 = m_gcnt;
    a_raw = 1'b0; b_raw = 1'b0;
    tick();
    a_raw = 1'b1; b_raw = 1'b1;
    ticks(2);
    check("ab_glitch_pre",  glitch_cnt, exp_gcnt(g0));
    tick();
    check("ab_glitch_step", glitch_cnt, exp_gcnt(g0 + 2));
    ticks(5);

    // Reset in the middle of a pending change on a.
    a_raw = 1'b0;
    ticks(3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_a_clean", {15'b0, a_clean}, 16'd1);
    check("rst_gcnt",    glitch_cnt, 16'd0);
    ticks(2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ticks(6);
    check("rst_rel_before", {15'b0, a_clean}, 16'd1);
    tick();
    check("rst_rel_at",     {15'b0, a_clean}, 16'd0);
    check("rst_rel_press",  {15'b0, btn_press}, 16'd0);
    a_raw = 1'b1;
    ticks(20);

    // Random bursts of varying widths on all three channels.
    for (int ch = 0; ch < 3; ch++) begin
      rem[ch] = 0;
      r[ch]   = idle_level(ch);
    end
    for (int i = 0; i < 600; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (rem[ch] == 0) begin
          r[ch]   = ~r[ch];
          rem[ch] = int'($urandom_range(1, 2 * DB + 2));
        end
        rem[ch]--;
      end
      a_raw = r[0]; b_raw = r[1]; btn_raw = r[2];
      tick();
    end
    a_raw = m_clean[0]; b_raw = m_clean[1]; btn_raw = m_clean[2];
    ticks(20);

    // Drive the glitch count near the top with rapid toggling on all channels.
    for (int i = 0; i < 60000 && m_gcnt < 65500; i++) begin
      a_raw = ~a_raw; b_raw = ~b_raw; btn_raw = ~btn_raw;
      tick(1'b0);
    end
    a_raw = m_clean[0]; b_raw = m_clean[1]; btn_raw = m_clean[2];
    ticks(10);
    for (int i = 0; i < 100 && m_gcnt < 65534; i++) begin
      a_raw = ~m_clean[0];
      tick(1'b0);
      a_raw = m_clean[0];
      ticks(4);
    end
    check("sat_preload", glitch_cnt, exp_gcnt(16'hFFFE));

    // Three simultaneous glitches from 0xFFFE saturate at 0xFFFF.
    for (int k = 0; k < 2; k++) begin
      a_raw = ~m_clean[0]; b_raw = ~m_clean[1]; btn_raw = ~m_clean[2];
      tick();
      a_raw = m_clean[0]; b_raw = m_clean[1]; btn_raw = m_clean[2];
      ticks(5);
      check("sat_hold", glitch_cnt, exp_gcnt(16'hFFFF));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pmod_enc_conditioner
